// File: rtl/sparc_pkg.sv
// Shared SPARC definitions: idle instruction, fetch FSM encodings and the
// instruction field positions that decode slices on.
package sparc_pkg;

  localparam logic [31:0] NOP_INST = 32'h0100_0000;

  // Fetch FSM encodings (kept as plain constants for legacy tooling).
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_WAIT = 2'd1;
  localparam fetch_state_t S_HOLD = 2'd2;

  // SPARC V9 instruction field positions.
  localparam int OP_HI     = 31;
  localparam int OP_LO     = 30;
  localparam int RD_HI     = 29;
  localparam int RD_LO     = 25;
  localparam int OP2_HI    = 24;
  localparam int OP2_LO    = 22;
  localparam int OP3_HI    = 24;
  localparam int OP3_LO    = 19;
  localparam int RS1_HI    = 18;
  localparam int RS1_LO    = 14;
  localparam int I_BIT     = 13;
  localparam int RS2_HI    = 4;
  localparam int RS2_LO    = 0;
  localparam int SIMM13_HI = 12;
  localparam int SIMM13_LO = 0;
  localparam int DISP22_HI = 21;
  localparam int DISP22_LO = 0;
  localparam int DISP30_HI = 29;
  localparam int DISP30_LO = 0;

  function automatic logic is_nop(input logic [31:0] word);
    return word == NOP_INST;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory channel: valid/ready request, valid-only response.
// Request handshake: a request transfers on a rising edge where imem_req_valid
// and imem_req_ready are both 1; the address is held stable while valid waits.
// Response: imem_resp_data is meaningful only in a cycle with imem_resp_valid=1.
interface instruction_fetch_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_INST_WIDTH = 32
) ();
    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [BUS_DATA_WIDTH-1:0] imem_req_addr;
    logic                      imem_resp_valid;
    logic [BUS_INST_WIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one memory request in flight and hands each
// fetched word with its PC+4 to decode, with redirect for taken branches/calls.
module instruction_fetch
    import sparc_pkg::*;
#(
    parameter int                    BUS_DATA_WIDTH = 64,
    parameter int                    BUS_INST_WIDTH = 32,
    parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_ready,
    input  logic                      redirect_valid,
    input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
    instruction_fetch_if.master       imem,
    output logic [BUS_DATA_WIDTH-1:0] IF_PCplus4_out,
    output logic [BUS_INST_WIDTH-1:0] inst,
    output logic [1:0]                state_dbg
);

    localparam logic [BUS_INST_WIDTH-1:0] NOP_W = BUS_INST_WIDTH'(NOP_INST);
    localparam logic [BUS_DATA_WIDTH-1:0] FOUR  = BUS_DATA_WIDTH'(4);

    fetch_state_t              state;
    logic [BUS_DATA_WIDTH-1:0] pc;
    logic [BUS_DATA_WIDTH-1:0] pc_plus4;
    logic [BUS_INST_WIDTH-1:0] held;
    logic                      drain;
    logic                      handoff;
    logic                      req_fire;

    assign pc_plus4 = pc + FOUR;
    assign req_fire = (state == S_REQ) && imem.imem_req_ready;

    always_comb begin
        handoff             = !reset && (state == S_HOLD) && id_ready && !redirect_valid;
        imem.imem_req_valid = !reset && (state == S_REQ);
        imem.imem_req_addr  = pc;
        inst                = NOP_W;
        IF_PCplus4_out      = '0;
        if (handoff) begin
            inst           = held;
            IF_PCplus4_out = pc_plus4;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= S_REQ;
            held  <= NOP_W;
            drain <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            case (state)
                S_REQ: begin
                    // Memory took a request for the old PC; its reply is stale.
                    if (req_fire) begin
                        drain <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        drain <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        drain <= 1'b1;
                    end
                end
                S_HOLD: begin
                    held  <= NOP_W;
                    state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        if (drain) begin
                            drain <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            held  <= imem.imem_resp_data;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (handoff) begin
                        pc    <= pc_plus4;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small latency-programmable
// instruction memory returning mem[a] = a | 32'h80000000.
module tb_instruction_fetch;
  import sparc_pkg::*;

  localparam int DW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [DW-1:0] redirect_pc = '0;
  logic [DW-1:0] IF_PCplus4_out;
  logic [IW-1:0] inst;
  logic [1:0]    state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  // memory model controls
  int            mem_lat = 1;
  int            mem_cnt = 0;
  logic [IW-1:0] mem_pending = '0;

  instruction_fetch_if #(.BUS_DATA_WIDTH(DW), .BUS_INST_WIDTH(IW)) imem_if ();

  instruction_fetch #(
    .BUS_DATA_WIDTH(DW),
    .BUS_INST_WIDTH(IW),
    .RESET_PC(64'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_ready(id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem(imem_if.master),
    .IF_PCplus4_out(IF_PCplus4_out),
    .inst(inst),
    .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    imem_if.imem_req_ready = 1'b1;
  end

  // memory: response appears mem_lat cycles after the accepting edge
  always @(posedge clk) begin
    if (reset) begin
      mem_cnt <= 0;
      imem_if.imem_resp_valid <= 1'b0;
      imem_if.imem_resp_data <= '0;
    end else begin
      imem_if.imem_resp_valid <= 1'b0;
      if (mem_cnt == 1) begin
        imem_if.imem_resp_valid <= 1'b1;
        imem_if.imem_resp_data <= mem_pending;
        mem_cnt <= 0;
      end else if (mem_cnt > 1) begin
        mem_cnt <= mem_cnt - 1;
      end
      if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
        if (mem_lat <= 1) begin
          imem_if.imem_resp_valid <= 1'b1;
          imem_if.imem_resp_data <= imem_if.imem_req_addr[IW-1:0] | 32'h8000_0000;
        end else begin
          mem_pending <= imem_if.imem_req_addr[IW-1:0] | 32'h8000_0000;
          mem_cnt <= mem_lat - 1;
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_inst"}, DW'(inst), DW'(NOP_INST));
    check({tag, "_pc4"}, IF_PCplus4_out, '0);
  endtask

  initial begin
    // reset held for two cycles
    next_cycle();
    settle();
    check("rst_req_valid", DW'(imem_if.imem_req_valid), 64'd0);
    check_idle("rst");
    next_cycle();
    reset = 1'b0;
    id_ready = 1'b1;
    settle();

    // first fetch from RESET_PC
    check("t1_req_valid", DW'(imem_if.imem_req_valid), 64'd1);
    check("t1_req_addr", imem_if.imem_req_addr, 64'h0);
    check("t1_state", DW'(state_dbg), DW'(S_REQ));
    next_cycle();
    check("t1_wait_valid", DW'(imem_if.imem_req_valid), 64'd0);
    check_idle("t1_wait");
    next_cycle();
    check("t1_inst", DW'(inst), 64'h8000_0000);
    check("t1_pc4", IF_PCplus4_out, 64'h4);
    next_cycle();
    check("t1_next_addr", imem_if.imem_req_addr, 64'h4);
    check("t1_next_valid", DW'(imem_if.imem_req_valid), 64'd1);
    check_idle("t1_next");

    // decode stalls for 5 cycles in S_HOLD
    id_ready = 1'b0;
    next_cycle();
    next_cycle();
    check("t2_state", DW'(state_dbg), DW'(S_HOLD));
    for (int i = 0; i < 5; i++) begin
      check_idle("t2_stall");
      check("t2_stall_req", DW'(imem_if.imem_req_valid), 64'd0);
      if (i != 4) next_cycle();
    end
    next_cycle();
    id_ready = 1'b1;
    settle();
    check("t2_inst", DW'(inst), 64'h8000_0004);
    check("t2_pc4", IF_PCplus4_out, 64'h8);
    next_cycle();
    check_idle("t2_after");
    check("t2_next_addr", imem_if.imem_req_addr, 64'h8);

    // redirect in S_WAIT; stale response arrives two cycles later
    mem_lat = 3;
    next_cycle();
    check("t3_state", DW'(state_dbg), DW'(S_WAIT));
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    settle();
    check_idle("t3_redir");
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    check_idle("t3_wait1");
    next_cycle();
    check("t3_stale_resp", DW'(imem_if.imem_resp_valid), 64'd1);
    check_idle("t3_stale");
    mem_lat = 1;
    next_cycle();
    check("t3_req_valid", DW'(imem_if.imem_req_valid), 64'd1);
    check("t3_req_addr", imem_if.imem_req_addr, 64'h100);
    check_idle("t3_req");

    // redirect together with id_ready in S_HOLD
    next_cycle();
    next_cycle();
    check("t4_state", DW'(state_dbg), DW'(S_HOLD));
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    settle();
    check_idle("t4_redir");
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    check("t4_req_addr", imem_if.imem_req_addr, 64'h200);
    check("t4_state_req", DW'(state_dbg), DW'(S_REQ));
    check_idle("t4_req");

    // memory not ready for 4 cycles
    imem_if.imem_req_ready = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_valid", DW'(imem_if.imem_req_valid), 64'd1);
      check("t5_hold_addr", imem_if.imem_req_addr, 64'h200);
      next_cycle();
    end
    imem_if.imem_req_ready = 1'b1;
    next_cycle();
    check("t5_wait_state", DW'(state_dbg), DW'(S_WAIT));

    // reset mid-S_WAIT, with the response present that cycle
    reset = 1'b1;
    settle();
    check("t5_rst_resp", DW'(imem_if.imem_resp_valid), 64'd1);
    check_idle("t5_rst");
    next_cycle();
    reset = 1'b0;
    settle();
    check("t5_state_after_rst", DW'(state_dbg), DW'(S_REQ));
    check("t5_addr_after_rst", imem_if.imem_req_addr, 64'h0);
    check("t5_valid_after_rst", DW'(imem_if.imem_req_valid), 64'd1);

    // redirect in S_REQ while memory accepts; PC wraps on handoff
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    check("t6_drain_state", DW'(state_dbg), DW'(S_WAIT));
    check_idle("t6_drain");
    next_cycle();
    check("t6_req_addr", imem_if.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    next_cycle();
    check("t6_inst", DW'(inst), 64'hFFFF_FFFC);
    check("t6_pc4_wrap", IF_PCplus4_out, 64'h0);
    next_cycle();
    check("t6_wrap_addr", imem_if.imem_req_addr, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    tests_failed++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the SPARC pipeline, directly upstream of instruction decode. Holds the PC and issues one request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. Hands each fetched word with its PC+4 to decode, gated by decode's id_ready. Accepts a redirect from a later stage for taken branches and calls.

Parameters:
BUS_DATA_WIDTH, 64, PC and address width
BUS_INST_WIDTH, 32, instruction width
RESET_PC, 64'h0, PC value loaded on reset
NOP_INST, 32'h01000000, SPARC nop driven whenever no instruction is being handed off

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
id_ready  in  1  decode can accept an instruction this cycle
redirect_valid  in  1  one-cycle pulse: taken branch or call
redirect_pc  in  BUS_DATA_WIDTH  new fetch PC when redirect_valid=1
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  BUS_DATA_WIDTH  fetch address (current PC)
imem_resp_valid  in  1  response data valid
imem_resp_data  in  BUS_INST_WIDTH  fetched instruction
IF_PCplus4_out  out  BUS_DATA_WIDTH  PC+4 of the handed-off instruction; 0 otherwise
inst  out  BUS_INST_WIDTH  handed-off instruction; NOP_INST otherwise

Behaviour:
- State: pc register, held-instruction register, drain flag, FSM {S_REQ, S_WAIT, S_HOLD}.
- Reset: pc=RESET_PC, state=S_REQ, held=NOP_INST, drain=0. Outputs: imem_req_valid=0, inst=NOP_INST, IF_PCplus4_out=0. Reset overrides redirect and response in the same cycle. Reset takes effect in any state. Instruction memory shares the same reset, so no response arrives for a request issued before reset.
- S_REQ: imem_req_valid=1, imem_req_addr=pc. When imem_req_ready=1, go to S_WAIT.
- S_WAIT: imem_req_valid=0. When imem_resp_valid=1 and drain=0: latch imem_resp_data into held and go to S_HOLD. When imem_resp_valid=1 and drain=1: discard the data, clear drain, and go to S_REQ.
- S_HOLD: handoff fires when id_ready=1 and redirect_valid=0. In the handoff cycle (combinational), inst=held and IF_PCplus4_out=pc+4. At the next edge, pc<=pc+4 and state goes to S_REQ.
- Outside a handoff cycle, inst=NOP_INST and IF_PCplus4_out=0. Decode treats NOP_INST as idle, so each instruction appears for exactly one cycle.
- Fetched word equal to NOP_INST: handed off normally. Decode ignores it, but the PC still advances.
- Redirect (redirect_valid=1), which has priority over everything except reset:
  - pc<=redirect_pc.
  - In S_REQ: stay in S_REQ. If imem_req_ready=1 in the same cycle, the accepted request is stale, so set drain=1 and go to S_WAIT.
  - In S_WAIT without a response that cycle: set drain=1 and stay in S_WAIT. With a response that cycle: discard it and go to S_REQ.
  - In S_HOLD: no handoff; discard held and go to S_REQ.
- Latency: minimum 3 cycles from request issue to handoff when memory accepts immediately and responds the next cycle. Throughput is one instruction per 3 cycles.
- PC arithmetic is modulo 2^BUS_DATA_WIDTH; wrap-around is silent. Low two PC bits are not checked.
- At most one outstanding memory request.

Decomposition:
- Shared package (sparc_pkg): NOP_INST constant, fetch FSM state enum, and the SPARC field-position constants also used by decode.
- No sub-module; single module.

Test Plan:
- Reset, memory always ready, 1-cycle response returning mem[a]=a|32'h80000000 -> first request addr 0. Handoff inst=32'h80000000, IF_PCplus4_out=4. Next request addr 4.
- Hold id_ready=0 for 5 cycles in S_HOLD -> inst=NOP_INST and no new request throughout. Single handoff on the cycle id_ready rises.
- Redirect to 0x100 in S_WAIT, old response arrives 2 cycles later -> old data never appears on inst. Next request addr 0x100.
- Redirect to 0x200 in the same cycle as id_ready=1 in S_HOLD -> inst=NOP_INST that cycle. Next request addr 0x200.
- imem_req_ready low for 4 cycles -> imem_req_valid and imem_req_addr stable. Assert reset mid-S_WAIT -> next cycle state S_REQ with addr RESET_PC.
